regfile_wb_ctrl: RTL
====================

// Module: regfile_wb_ctrl
// PURPOSE
// Write-side controller for the 32x32 register file. Merges writebacks from the
// single-cycle pipeline WB stage and a long-latency unit (load/mul/div) into the
// file's single write port (we/rW/win), queuing long-latency results in a FIFO.
// Keeps a per-register busy scoreboard to stall decode on pending long-latency
// destinations, and forwards same-cycle writes onto the decode read operands.
// PARAMETERS
// LQ_DEPTH  4   long-latency result FIFO entries (power of 2, >=2)
// LQ_AW     2   log2(LQ_DEPTH)
// PORTS
// clk       in   1   clock; all state updates on posedge
// rst_n     in   1   synchronous active-low reset
// p_we      in   1   pipeline WB write enable (never back-pressured)
// p_rW      in   5   pipeline WB destination
// p_win     in   32  pipeline WB data
// l_valid   in   1   long-latency result valid
// l_ready   out  1   FIFO can accept (= not full, 0 in reset)
// l_rW      in   5   long-latency destination
// l_win     in   32  long-latency data
// iss_valid in   1   decode issues a long-latency op this cycle (only when !stall)
// iss_rd    in   5   its destination; sets busy bit
// rA,rB     in   5   decode source registers
// rD        in   5   decode destination (any op)
// rf_A,rf_B in   32  register file read data for rA/rB
// A,B       out  32  forwarded operands to decode
// stall     out  1   decode must hold
// we,rW,win out  1/5/32 register file write port
// BEHAVIOUR
// - Reset (rst_n=0 at posedge): FIFO empty, busy[31:0]=0; l_ready=0 while rst_n=0.
//   With FIFO empty and p_we=0: we=0, rW=0, win=0. Reset mid-drain discards FIFO.
// - Accept: l_valid&&l_ready pushes {l_rW,l_win} at posedge. l_rW==0 accepted but
//   not pushed, not written. Full: l_ready=0, producer holds data stable.
// - Write mux (combinational): p_we&&p_rW!=0 -> write pipeline data, FIFO holds.
//   Else FIFO non-empty -> write head, pop at posedge. Else we=0.
//   Pipeline always has priority; FIFO drains only on idle pipeline cycles.
// - Push and pop same cycle when full is legal: l_ready=0 when full, so no push;
//   when not full, push+pop leaves count unchanged. Pointers wrap mod LQ_DEPTH.
// - Scoreboard: iss_valid&&iss_rd!=0 sets busy[iss_rd]; a FIFO pop of rW clears
//   busy[rW]. Set and clear of same reg same cycle -> set wins. busy[0] always 0.
// - stall = busy[rA]|busy[rB]|busy[rD] (r0 never busy). Prevents RAW on pending
//   long results and WAW by pipeline onto a busy destination.
// - Forwarding: A = (we && rW==rA && rA!=0) ? win : rf_A; B likewise. Covers the
//   write landing at the same edge as decode reads. rA==0 -> rf_A (file returns 0).
// - Latency: pipeline write 0 cycles (visible in file after next edge); long result
//   >=1 cycle after accept, more if pipeline busy. No starvation guarantee.
// CONFIGURATION
// REGFILE_WB_BYPASS_EN defined: forwarding as above.
// Not defined: A=rf_A, B=rf_B; stall additionally asserts when we&&rW!=0&&
//   (rW==rA||rW==rB), so decode re-reads after the write lands.
// TESTING
// 1 Reset: rst_n=0 2 cycles -> l_ready=0, we=0, stall=0; release -> l_ready=1.
// 2 p_we=1,p_rW=5,p_win=0xDEAD, rA=5, rf_A=0 -> we=1,rW=5, A=0xDEAD (BYPASS_EN);
//   without macro -> A=0, stall=1.
// 3 iss rd=8; decode rA=8 -> stall=1 until l result {8,0x1234} pops; next cycle
//   stall=0, file r8=0x1234.
// 4 Hold p_we=1 (rW=3) for 6 cycles, push 4 l results -> l_ready=0 after 4th;
//   drop p_we -> drain 4 writes in FIFO order, one per cycle, l_ready=1 after first pop.
// 5 Same-cycle iss_rd=9 and pop of rW=9 -> busy[9]=1 afterwards.
// 6 p_rW=0 / l_rW=0 writes -> we=0 for both, no FIFO entry, A for rA=0 = rf_A.

Source files
------------

// File: rtl/regfile_wb_ctrl.sv
// regfile_wb_ctrl: write-side controller for the 32x32 register file.
// Merges pipeline WB writes with queued long-latency results onto the single
// write port, tracks pending long-latency destinations in a busy scoreboard,
// and forwards same-cycle writes onto the decode operands.
// Optional feature macro: REGFILE_WB_BYPASS_EN (forwarding enabled when defined;
// otherwise decode stalls on a same-cycle write to one of its sources).
module regfile_wb_ctrl #(
  parameter int LQ_DEPTH = 4,
  parameter int LQ_AW    = 2,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p_we,
  input  logic [4:0]        p_rW,
  input  logic [DATA_W-1:0] p_win,
  input  logic              l_valid,
  output logic              l_ready,
  input  logic [4:0]        l_rW,
  input  logic [DATA_W-1:0] l_win,
  input  logic              iss_valid,
  input  logic [4:0]        iss_rd,
  input  logic [4:0]        rA,
  input  logic [4:0]        rB,
  input  logic [4:0]        rD,
  input  logic [DATA_W-1:0] rf_A,
  input  logic [DATA_W-1:0] rf_B,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              stall,
  output logic              we,
  output logic [4:0]        rW,
  output logic [DATA_W-1:0] win
);

  // Long-latency result queue: storage is data-only, pointers/count are control.
  logic [DATA_W-1:0] lq_data [LQ_DEPTH];
  logic [4:0]        lq_rd   [LQ_DEPTH];
  logic [LQ_AW-1:0]  wr_ptr;
  logic [LQ_AW-1:0]  rd_ptr;
  logic [LQ_AW:0]    count;
  logic [31:0]       busy;
  logic [31:0]       busy_nxt;

  logic lq_empty;
  logic lq_full;
  logic push;
  logic pop;
  logic pipe_wr;

  assign lq_empty = (count == '0);
  assign lq_full  = (count == (LQ_AW+1)'(LQ_DEPTH));
  assign l_ready  = rst_n & ~lq_full;

  // Results for r0 are handshaken but dropped, so they never occupy a slot.
  assign push    = l_valid & l_ready & (l_rW != 5'd0);
  assign pipe_wr = p_we & (p_rW != 5'd0);
  // The queue only drains on cycles the pipeline leaves the port idle.
  assign pop     = ~pipe_wr & ~lq_empty;

  // Write-port mux: pipeline first, then queue head, else idle with zeros.
  always_comb begin
    we  = 1'b0;
    rW  = 5'd0;
    win = '0;
    if (pipe_wr) begin
      we  = 1'b1;
      rW  = p_rW;
      win = p_win;
    end else if (!lq_empty) begin
      we  = 1'b1;
      rW  = lq_rd[rd_ptr];
      win = lq_data[rd_ptr];
    end
  end

  // Queue pointers and occupancy; reset discards anything still queued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + LQ_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + LQ_AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (LQ_AW+1)'(1);
        2'b01:   count <= count - (LQ_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Queue storage; contents are meaningless until counted, so no reset.
  always_ff @(posedge clk) begin
    if (push) begin
      lq_data[wr_ptr] <= l_win;
      lq_rd[wr_ptr]   <= l_rW;
    end
  end

  // Scoreboard next state: pop clears, issue sets afterwards so set wins.
  always_comb begin
    busy_nxt = busy;
    if (pop) busy_nxt[lq_rd[rd_ptr]] = 1'b0;
    if (iss_valid && (iss_rd != 5'd0)) busy_nxt[iss_rd] = 1'b1;
    busy_nxt[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (!rst_n) busy <= '0;
    else        busy <= busy_nxt;
  end

`ifdef REGFILE_WB_BYPASS_EN
  // Same-cycle writes are forwarded, so only pending long results stall.
  always_comb begin
    stall = busy[rA] | busy[rB] | busy[rD];
    A     = (we && (rW == rA) && (rA != 5'd0)) ? win : rf_A;
    B     = (we && (rW == rB) && (rB != 5'd0)) ? win : rf_B;
  end
`else
  // No forwarding: decode holds until the in-flight write has landed.
  always_comb begin
    stall = busy[rA] | busy[rB] | busy[rD] |
            (we && (rW != 5'd0) && ((rW == rA) || (rW == rB)));
    A     = rf_A;
    B     = rf_B;
  end
`endif

endmodule
